// File: rtl/gray_pkg.sv
// Shared types and the Gray-to-binary decode used by the Gray step monitor.
package gray_pkg;

  typedef enum logic [1:0] {FILL, PRIME, RUN} state_t;

  localparam int GRAY_MAX_W = 32;

  // Works for any width up to GRAY_MAX_W: zero-extended upper Gray bits decode to zero.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// SYNC_STAGES-deep register chain that samples the upstream Gray count.
module gray_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_p [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_p[i] <= '0;
      end
    end else begin
      stage_p[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_p[i] <= stage_p[i-1];
      end
    end
  end

  assign dout = stage_p[SYNC_STAGES-1];

endmodule

// File: rtl/gray_step_monitor.sv
// Decodes a sampled Gray count and classifies each change as up-step, down-step or illegal jump.
module gray_step_monitor
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 locked,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 wrap,
  output logic                 err,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic [WIDTH-1:0]  g_s;
  logic [WIDTH-1:0]  b_s;
  logic [WIDTH-1:0]  prev;
  logic [FILL_W-1:0] fill_cnt;
  state_t            state, state_next;
  logic              is_up, is_dn, is_err, is_wrap;

  // Input sampling stages
  gray_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (gray_in),
    .dout (g_s)
  );

  assign b_s = WIDTH'(gray2bin(GRAY_MAX_W'(g_s)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == FILL) fill_cnt <= fill_cnt + FILL_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (fill_cnt == FILL_W'(SYNC_STAGES - 1)) state_next = PRIME;
      PRIME:   state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    is_up   = 1'b0;
    is_dn   = 1'b0;
    is_err  = 1'b0;
    is_wrap = 1'b0;
    if (state == RUN && b_s != prev) begin
      if (b_s == prev + WIDTH'(1)) begin
        is_up   = 1'b1;
        is_wrap = (prev == '1);
      end else if (b_s == prev - WIDTH'(1)) begin
        is_dn   = 1'b1;
        is_wrap = (prev == '0);
      end else begin
        is_err  = 1'b1;
      end
    end
  end

  // Registered outputs; an error in the same cycle as clr_err leaves a count of one
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      bin_out  <= '0;
      locked   <= 1'b0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      wrap     <= 1'b0;
      err      <= 1'b0;
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else begin
      step_up <= is_up;
      step_dn <= is_dn;
      wrap    <= is_wrap;
      err     <= is_err;
      locked  <= (state_next == RUN);
      if (state != FILL) begin
        prev    <= b_s;
        bin_out <= b_s;
      end
      if (is_err) begin
        err_cnt  <= clr_err ? ERR_CNT_W'(1) : sat_inc(err_cnt);
        err_flag <= 1'b1;
      end else if (clr_err && state == RUN) begin
        err_cnt  <= '0;
        err_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Scoreboard bench for gray_step_monitor: default instance plus a 2-bit error counter instance.
module tb_gray_step_monitor;

  localparam int S = 2;

  typedef struct {
    logic [3:0] g;
    logic       clr;
    logic [3:0] bin;
    logic [1:0] kind;   // 0 none, 1 up, 2 down, 3 err
    logic       wrap;
  } vec_t;

  typedef struct {
    int         tag;
    logic       clr;
    logic [3:0] bin;
    logic [1:0] kind;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray_in = 4'd0;
  logic       clr_err = 1'b0;

  logic [3:0] bin_out, bin_out2;
  logic       locked, step_up, step_dn, wrap, err, err_flag;
  logic       locked2, step_up2, step_dn2, wrap2, err2, err_flag2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  exp_t q[$];
  bit   m_primed;
  int   m_cnt8, m_cnt2;
  bit   m_flag;

  always #5 clk = ~clk;

  gray_step_monitor dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin_out), .locked(locked), .step_up(step_up), .step_dn(step_dn),
    .wrap(wrap), .err(err), .err_flag(err_flag), .err_cnt(err_cnt)
  );

  gray_step_monitor #(.WIDTH(4), .SYNC_STAGES(S), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin_out2), .locked(locked2), .step_up(step_up2), .step_dn(step_dn2),
    .wrap(wrap2), .err(err2), .err_flag(err_flag2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0d expected=%0d", name, edge_cnt, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_locked"}, {31'd0, locked}, 0);
    chk({tag, "_locked2"}, {31'd0, locked2}, 0);
    chk({tag, "_bin"}, {28'd0, bin_out}, 0);
    chk({tag, "_pulses"}, {28'd0, step_up, step_dn, wrap, err}, 0);
    chk({tag, "_cnt"}, {24'd0, err_cnt}, 0);
    chk({tag, "_flag"}, {31'd0, err_flag}, 0);
    chk({tag, "_cnt2"}, {30'd0, err_cnt2}, 0);
  endtask

  task automatic score();
    exp_t e;
    if (q.size() > 0 && q[0].tag + S == edge_cnt) begin
      e = q.pop_front();
      if (!m_primed) begin
        m_primed = 1'b1;
      end else if (e.kind == 2'd3) begin
        m_cnt8 = e.clr ? 1 : ((m_cnt8 < 255) ? m_cnt8 + 1 : 255);
        m_cnt2 = e.clr ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
        m_flag = 1'b1;
      end else if (e.clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
        m_flag = 1'b0;
      end
      chk("locked", {31'd0, locked}, 1);
      chk("bin_out", {28'd0, bin_out}, {28'd0, e.bin});
      chk("bin_out2", {28'd0, bin_out2}, {28'd0, e.bin});
      chk("step_up", {31'd0, step_up}, {31'd0, e.kind == 2'd1});
      chk("step_dn", {31'd0, step_dn}, {31'd0, e.kind == 2'd2});
      chk("err", {31'd0, err}, {31'd0, e.kind == 2'd3});
      chk("wrap", {31'd0, wrap}, {31'd0, e.wrap});
      chk("err_cnt", {24'd0, err_cnt}, m_cnt8);
      chk("err_cnt_w2", {30'd0, err_cnt2}, m_cnt2);
      chk("err_flag", {31'd0, err_flag}, {31'd0, m_flag});
      chk("err_flag_w2", {31'd0, err_flag2}, {31'd0, m_flag});
    end else begin
      chk_idle("prelock");
    end
  endtask

  // One clock: clr_err is aimed at the edge where the oldest queued value is classified.
  task automatic cyc(input vec_t v);
    exp_t e;
    gray_in = v.g;
    clr_err = (q.size() > 0 && q[0].tag + S == edge_cnt + 1) ? q[0].clr : 1'b0;
    @(posedge clk);
    edge_cnt++;
    e.tag = edge_cnt; e.clr = v.clr; e.bin = v.bin; e.kind = v.kind; e.wrap = v.wrap;
    q.push_back(e);
    #1;
    score();
  endtask

  task automatic do_reset(input logic [3:0] g);
    rst = 1'b1;
    gray_in = g;
    clr_err = 1'b0;
    @(posedge clk);
    edge_cnt++;
    q.delete();
    m_primed = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_flag = 1'b0;
    #1;
    chk_idle("reset");
    rst = 1'b0;
  endtask

  vec_t tbl[20];
  vec_t v;
  logic [3:0] bv;

  initial begin
    tbl[0]  = '{4'b0001, 1'b0, 4'd1,  2'd1, 1'b0};
    tbl[1]  = '{4'b0011, 1'b0, 4'd2,  2'd1, 1'b0};
    tbl[2]  = '{4'b0001, 1'b0, 4'd1,  2'd2, 1'b0};
    tbl[3]  = '{4'b0000, 1'b0, 4'd0,  2'd2, 1'b0};
    tbl[4]  = '{4'b1000, 1'b0, 4'd15, 2'd2, 1'b1};
    tbl[5]  = '{4'b0000, 1'b0, 4'd0,  2'd1, 1'b1};
    tbl[6]  = '{4'b0100, 1'b0, 4'd7,  2'd3, 1'b0};
    tbl[7]  = '{4'b0100, 1'b1, 4'd7,  2'd0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 4'd0,  2'd3, 1'b0};
    tbl[9]  = '{4'b0100, 1'b0, 4'd7,  2'd3, 1'b0};
    tbl[10] = '{4'b0000, 1'b0, 4'd0,  2'd3, 1'b0};
    tbl[11] = '{4'b0100, 1'b0, 4'd7,  2'd3, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 4'd0,  2'd3, 1'b0};
    tbl[13] = '{4'b0000, 1'b1, 4'd0,  2'd0, 1'b0};
    tbl[14] = '{4'b0100, 1'b1, 4'd7,  2'd3, 1'b0};
    tbl[15] = '{4'b0101, 1'b0, 4'd6,  2'd2, 1'b0};
    tbl[16] = '{4'b0111, 1'b0, 4'd5,  2'd2, 1'b0};
    tbl[17] = '{4'b0111, 1'b0, 4'd5,  2'd0, 1'b0};
    tbl[18] = '{4'b0111, 1'b0, 4'd5,  2'd0, 1'b0};
    tbl[19] = '{4'b0111, 1'b0, 4'd5,  2'd0, 1'b0};

    do_reset(4'b0000);

    // Full up-count sweep, each value held for two cycles.
    v = '{4'b0000, 1'b0, 4'd0, 2'd0, 1'b0};
    cyc(v);
    cyc(v);
    for (int i = 1; i <= 16; i++) begin
      bv = 4'(i);
      v = '{bv ^ (bv >> 1), 1'b0, bv, 2'd1, (bv == 4'd0)};
      cyc(v);
      v.kind = 2'd0;
      v.wrap = 1'b0;
      cyc(v);
    end

    for (int i = 0; i < 20; i++) cyc(tbl[i]);

    // Reset while running at 5 with the input already moved to 12.
    do_reset(4'b1010);
    v = '{4'b1010, 1'b0, 4'd12, 2'd0, 1'b0};
    for (int i = 0; i < S + 4; i++) cyc(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
